// File: rtl/pcie_dllp_rx_decoder_pkg.sv
// rtl/pcie_dllp_rx_decoder_pkg.sv - DLLP layouts, type codes and FC-init states for the RX DLLP decoder
package pcie_dllp_rx_decoder_pkg;

   localparam int SEQ_BITS = 12;

   localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
   localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

   localparam logic [7:0] DLLP_ACK = 8'h00;
   localparam logic [7:0] DLLP_NAK = 8'h10;

   // FC DLLPs: type[7:6] selects the kind, type[5:4] the credit type, type[3] is zero, type[2:0] the VC
   localparam logic [1:0] FC_KIND_INIT1  = 2'b01;
   localparam logic [1:0] FC_KIND_INIT2  = 2'b11;
   localparam logic [1:0] FC_KIND_UPDATE = 2'b10;

   localparam logic [1:0] FC_P   = 2'd0;
   localparam logic [1:0] FC_NP  = 2'd1;
   localparam logic [1:0] FC_CPL = 2'd2;

   typedef enum logic [1:0] {
      FC_INIT1 = 2'd0,
      FC_INIT2 = 2'd1,
      FC_DONE  = 2'd2
   } fc_state_t;

   typedef struct packed {
      logic [15:0] crc;
      logic [7:0]  acknak_seq_num_l;
      logic [3:0]  rsvd2;
      logic [3:0]  acknak_seq_num_h;
      logic [7:0]  rsvd1;
      logic [7:0]  dllp_type;
   } dllp_ACKNAK_packet_t;

   typedef struct packed {
      logic [15:0] crc;
      logic [7:0]  data_fc_l;
      logic [1:0]  hdr_fc_l;
      logic [1:0]  data_scale;
      logic [3:0]  data_fc_h;
      logic [1:0]  hdr_scale;
      logic [5:0]  hdr_fc_h;
      logic [7:0]  dllp_type;
   } dllp_FC_packet_t;

endpackage

// File: rtl/pcie_dllp_rx_decoder_crc.sv
// rtl/pcie_dllp_rx_decoder_crc.sv - combinational DLLP CRC16 over bytes 0..3, returned in wire layout
module pcie_dllp_rx_decoder_crc
   import pcie_dllp_rx_decoder_pkg::*;
(
   input  logic [31:0] data,
   output logic [15:0] crc_field
);

   logic [15:0] lfsr;
   logic [15:0] crc_inv;
   logic        fb;

   // Bytes are consumed bit 0 first; the complemented remainder goes out with each byte bit-reversed.
   always_comb begin
      lfsr      = DLLP_CRC_SEED;
      fb        = 1'b0;
      crc_field = '0;
      for (int i = 0; i < 32; i++) begin
         fb   = lfsr[15] ^ data[i];
         lfsr = {lfsr[14:0], 1'b0};
         if (fb) begin
            lfsr = lfsr ^ DLLP_CRC_POLY;
         end
      end
      crc_inv = ~lfsr;
      for (int j = 0; j < 8; j++) begin
         crc_field[j]     = crc_inv[15 - j];
         crc_field[8 + j] = crc_inv[7 - j];
      end
   end

endmodule

// File: rtl/pcie_dllp_rx_decoder.sv
// rtl/pcie_dllp_rx_decoder.sv - RX DLLP consumer: CRC check, Ack/Nak tracking, VC0 FC-init and credit limits
module pcie_dllp_rx_decoder
   import pcie_dllp_rx_decoder_pkg::*;
#(
   parameter logic [2:0] VC_ID = 3'd0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                dl_up_i,
   input  logic                dllp_valid_i,
   input  logic [47:0]         dllp_i,
   input  logic [SEQ_BITS-1:0] next_tx_seq_i,
   output logic [SEQ_BITS-1:0] ackd_seq_o,
   output logic                ack_upd_o,
   output logic                replay_req_o,
   output logic                crc_err_o,
   output logic                proto_err_o,
   output logic [7:0]          p_hdr_cl_o,
   output logic [7:0]          np_hdr_cl_o,
   output logic [7:0]          cpl_hdr_cl_o,
   output logic [11:0]         p_data_cl_o,
   output logic [11:0]         np_data_cl_o,
   output logic [11:0]         cpl_data_cl_o,
   output logic [1:0]          p_inf_o,
   output logic [1:0]          np_inf_o,
   output logic [1:0]          cpl_inf_o,
   output logic                fc_init1_done_o,
   output logic                fc_init_done_o
);

   localparam logic [SEQ_BITS-1:0] SEQ_ONE = {{(SEQ_BITS-1){1'b0}}, 1'b1};

   logic        s1_valid;
   logic [47:0] s1_dllp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_dllp  <= '0;
      end else if (!dl_up_i) begin
         s1_valid <= 1'b0;
         s1_dllp  <= '0;
      end else begin
         s1_valid <= dllp_valid_i;
         s1_dllp  <= dllp_i;
      end
   end

   logic [15:0] crc_calc;

   pcie_dllp_rx_decoder_crc u_crc (
      .data      (s1_dllp[31:0]),
      .crc_field (crc_calc)
   );

   dllp_ACKNAK_packet_t acknak;
   dllp_FC_packet_t     fcp;
   logic                crc_ok;
   logic                good;
   logic [7:0]          dtype;

   assign acknak = dllp_ACKNAK_packet_t'(s1_dllp);
   assign fcp    = dllp_FC_packet_t'(s1_dllp);
   assign crc_ok = (crc_calc == s1_dllp[47:32]);
   assign good   = s1_valid && crc_ok;
   assign dtype  = s1_dllp[7:0];

   logic unused_fields;
   assign unused_fields = ^{acknak.rsvd1, acknak.rsvd2, acknak.crc,
                            fcp.hdr_scale, fcp.data_scale, fcp.crc};

   // Ack/Nak: sequence must lie behind NEXT_TRANSMIT_SEQ, and only forward steps move AckD_SEQ
   logic [SEQ_BITS-1:0] seq;
   logic [SEQ_BITS-1:0] seq_win;
   logic [SEQ_BITS-1:0] seq_adv;
   logic [SEQ_BITS-1:0] ackd_q;
   logic                is_acknak;
   logic                is_nak;
   logic                seq_ok;
   logic                do_adv;

   assign seq       = {acknak.acknak_seq_num_h, acknak.acknak_seq_num_l};
   assign seq_win   = (next_tx_seq_i - SEQ_ONE) - seq;
   assign seq_adv   = seq - ackd_q;
   assign is_nak    = (dtype == DLLP_NAK);
   assign is_acknak = good && ((dtype == DLLP_ACK) || is_nak);
   assign seq_ok    = !seq_win[SEQ_BITS-1];
   assign do_adv    = is_acknak && seq_ok && (seq_adv != '0) && !seq_adv[SEQ_BITS-1];

   logic ack_upd_q, replay_q, crc_err_q, proto_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ackd_q      <= '1;
         ack_upd_q   <= 1'b0;
         replay_q    <= 1'b0;
         crc_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else if (!dl_up_i) begin
         ackd_q      <= '1;
         ack_upd_q   <= 1'b0;
         replay_q    <= 1'b0;
         crc_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         if (do_adv) begin
            ackd_q <= seq;
         end
         ack_upd_q   <= do_adv;
         replay_q    <= is_acknak && seq_ok && is_nak;
         crc_err_q   <= s1_valid && !crc_ok;
         proto_err_q <= is_acknak && !seq_ok;
      end
   end

   // FC DLLP decode for the configured VC only
   logic [1:0] fc_kind;
   logic [1:0] fc_idx;
   logic       fc_ok;
   logic [7:0] fc_hdr;
   logic [11:0] fc_data;

   assign fc_kind = dtype[7:6];
   assign fc_idx  = dtype[5:4];
   assign fc_ok   = good && (fc_kind != 2'b00) && (fc_idx != 2'b11) &&
                    !dtype[3] && (dtype[2:0] == VC_ID);
   assign fc_hdr  = {fcp.hdr_fc_h, fcp.hdr_fc_l};
   assign fc_data = {fcp.data_fc_h, fcp.data_fc_l};

   fc_state_t  state_q, state_d;
   logic [2:0] rec_q, rec_d;
   logic       rec_we;
   logic       upd_we;

   always_comb begin
      state_d = state_q;
      rec_d   = rec_q;
      rec_we  = 1'b0;
      upd_we  = 1'b0;
      case (state_q)
         FC_INIT1: begin
            if (fc_ok && (fc_kind == FC_KIND_INIT1 || fc_kind == FC_KIND_INIT2)) begin
               rec_we = 1'b1;
               rec_d  = rec_q | (3'b001 << fc_idx);
               if (&rec_d) begin
                  state_d = FC_INIT2;
               end
            end
         end
         FC_INIT2: begin
            if (fc_ok && (fc_kind == FC_KIND_INIT2 || fc_kind == FC_KIND_UPDATE)) begin
               state_d = FC_DONE;
            end
         end
         FC_DONE: begin
            upd_we = fc_ok && (fc_kind == FC_KIND_UPDATE);
         end
         default: state_d = FC_INIT1;
      endcase
   end

   logic [7:0]  hdr_cl_q  [0:2];
   logic [11:0] data_cl_q [0:2];
   logic [1:0]  inf_q     [0:2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FC_INIT1;
         rec_q   <= '0;
         for (int i = 0; i < 3; i++) begin
            hdr_cl_q[i]  <= '0;
            data_cl_q[i] <= '0;
            inf_q[i]     <= '0;
         end
      end else if (!dl_up_i) begin
         state_q <= FC_INIT1;
         rec_q   <= '0;
         for (int i = 0; i < 3; i++) begin
            hdr_cl_q[i]  <= '0;
            data_cl_q[i] <= '0;
            inf_q[i]     <= '0;
         end
      end else begin
         state_q <= state_d;
         rec_q   <= rec_d;
         if (rec_we) begin
            hdr_cl_q[fc_idx]  <= fc_hdr;
            data_cl_q[fc_idx] <= fc_data;
            inf_q[fc_idx]     <= {fc_hdr == 8'd0, fc_data == 12'd0};
         end
         if (upd_we) begin
            if (!inf_q[fc_idx][1]) begin
               hdr_cl_q[fc_idx] <= fc_hdr;
            end
            if (!inf_q[fc_idx][0]) begin
               data_cl_q[fc_idx] <= fc_data;
            end
         end
      end
   end

   assign ackd_seq_o      = ackd_q;
   assign ack_upd_o       = ack_upd_q;
   assign replay_req_o    = replay_q;
   assign crc_err_o       = crc_err_q;
   assign proto_err_o     = proto_err_q;
   assign p_hdr_cl_o      = hdr_cl_q[FC_P];
   assign np_hdr_cl_o     = hdr_cl_q[FC_NP];
   assign cpl_hdr_cl_o    = hdr_cl_q[FC_CPL];
   assign p_data_cl_o     = data_cl_q[FC_P];
   assign np_data_cl_o    = data_cl_q[FC_NP];
   assign cpl_data_cl_o   = data_cl_q[FC_CPL];
   assign p_inf_o         = inf_q[FC_P];
   assign np_inf_o        = inf_q[FC_NP];
   assign cpl_inf_o       = inf_q[FC_CPL];
   assign fc_init1_done_o = (state_q != FC_INIT1);
   assign fc_init_done_o  = (state_q == FC_DONE);

endmodule

// File: tb/tb_pcie_dllp_rx_decoder.sv
// tb/tb_pcie_dllp_rx_decoder.sv - directed self-checking bench for pcie_dllp_rx_decoder
module tb_pcie_dllp_rx_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        dl_up_i;
   logic        dllp_valid_i;
   logic [47:0] dllp_i;
   logic [11:0] next_tx_seq_i;
   logic [11:0] ackd_seq_o;
   logic        ack_upd_o, replay_req_o, crc_err_o, proto_err_o;
   logic [7:0]  p_hdr_cl_o, np_hdr_cl_o, cpl_hdr_cl_o;
   logic [11:0] p_data_cl_o, np_data_cl_o, cpl_data_cl_o;
   logic [1:0]  p_inf_o, np_inf_o, cpl_inf_o;
   logic        fc_init1_done_o, fc_init_done_o;

   int total = 0;
   int bad   = 0;

   pcie_dllp_rx_decoder dut (
      .clk             (clk),
      .rst             (rst),
      .dl_up_i         (dl_up_i),
      .dllp_valid_i    (dllp_valid_i),
      .dllp_i          (dllp_i),
      .next_tx_seq_i   (next_tx_seq_i),
      .ackd_seq_o      (ackd_seq_o),
      .ack_upd_o       (ack_upd_o),
      .replay_req_o    (replay_req_o),
      .crc_err_o       (crc_err_o),
      .proto_err_o     (proto_err_o),
      .p_hdr_cl_o      (p_hdr_cl_o),
      .np_hdr_cl_o     (np_hdr_cl_o),
      .cpl_hdr_cl_o    (cpl_hdr_cl_o),
      .p_data_cl_o     (p_data_cl_o),
      .np_data_cl_o    (np_data_cl_o),
      .cpl_data_cl_o   (cpl_data_cl_o),
      .p_inf_o         (p_inf_o),
      .np_inf_o        (np_inf_o),
      .cpl_inf_o       (cpl_inf_o),
      .fc_init1_done_o (fc_init1_done_o),
      .fc_init_done_o  (fc_init_done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] mk(input logic [31:0] b);
      logic [15:0] r;
      logic [15:0] c;
      logic [15:0] f;
      r = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h100B;
         else              r = {r[14:0], 1'b0};
      end
      c = ~r;
      for (int j = 0; j < 8; j++) begin
         f[j]     = c[15 - j];
         f[8 + j] = c[7 - j];
      end
      return {f, b};
   endfunction

   function automatic logic [47:0] acknak(input logic nak, input logic [11:0] s);
      return mk({s[7:0], 4'h0, s[11:8], 8'h00, (nak ? 8'h10 : 8'h00)});
   endfunction

   function automatic logic [47:0] fc(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
      return mk({d[7:0], h[1:0], 2'b00, d[11:8], 2'b00, h[7:2], t});
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one DLLP and return at the negedge where its results are visible
   task automatic send(input logic [47:0] d);
      @(negedge clk);
      dllp_i       = d;
      dllp_valid_i = 1'b1;
      @(negedge clk);
      dllp_valid_i = 1'b0;
      @(negedge clk);
   endtask

   logic [47:0] tmp;

   initial begin
      rst           = 1'b1;
      dl_up_i       = 1'b1;
      dllp_valid_i  = 1'b0;
      dllp_i        = '0;
      next_tx_seq_i = 12'h00A;
      repeat (3) @(negedge clk);
      chk("rst_ackd", ackd_seq_o, 12'hFFF);
      chk("rst_pulses", {ack_upd_o, replay_req_o, crc_err_o, proto_err_o}, 4'b0000);
      chk("rst_fc", {fc_init1_done_o, fc_init_done_o, p_hdr_cl_o, p_data_cl_o, p_inf_o}, 0);
      rst = 1'b0;

      // 1: Ack advances AckD_SEQ from FFFh
      send(acknak(1'b0, 12'h005));
      chk("t1_ackd", ackd_seq_o, 12'h005);
      chk("t1_pulses", {ack_upd_o, replay_req_o, crc_err_o, proto_err_o}, 4'b1000);
      @(negedge clk);
      chk("t1_pulse_end", ack_upd_o, 1'b0);

      // 2: duplicate Nak still requests replay
      send(acknak(1'b1, 12'h005));
      chk("t2_pulses", {ack_upd_o, replay_req_o, crc_err_o, proto_err_o}, 4'b0100);
      chk("t2_ackd", ackd_seq_o, 12'h005);

      // 3: sequence beyond NEXT_TRANSMIT_SEQ
      send(acknak(1'b0, 12'h010));
      chk("t3_pulses", {ack_upd_o, replay_req_o, crc_err_o, proto_err_o}, 4'b0001);
      chk("t3_ackd", ackd_seq_o, 12'h005);

      // 4: corrupted CRC
      tmp     = acknak(1'b0, 12'h006);
      tmp[32] = ~tmp[32];
      send(tmp);
      chk("t4_pulses", {ack_upd_o, replay_req_o, crc_err_o, proto_err_o}, 4'b0010);
      chk("t4_ackd", ackd_seq_o, 12'h005);

      // 5: FC init; wrong-VC DLLP first must be discarded
      send(fc(8'h41, 8'h55, 12'h055));
      chk("t5_vc1", {p_hdr_cl_o, fc_init1_done_o}, {8'h00, 1'b0});
      send(fc(8'h40, 8'h20, 12'h100));
      send(fc(8'h50, 8'h01, 12'h000));
      chk("t5_np_init1", fc_init1_done_o, 1'b0);
      send(fc(8'h60, 8'h00, 12'h000));
      chk("t5_init1_done", {fc_init1_done_o, fc_init_done_o}, 2'b10);
      chk("t5_p_lim", {p_hdr_cl_o, p_data_cl_o, p_inf_o}, {8'h20, 12'h100, 2'b00});
      chk("t5_np_lim", {np_hdr_cl_o, np_data_cl_o, np_inf_o}, {8'h01, 12'h000, 2'b01});
      chk("t5_cpl_inf", cpl_inf_o, 2'b11);
      send(fc(8'h80, 8'h24, 12'h140));
      chk("t5_init_done", {fc_init1_done_o, fc_init_done_o}, 2'b11);
      chk("t5_init2_norec", {p_hdr_cl_o, p_data_cl_o}, {8'h20, 12'h100});
      send(fc(8'h80, 8'h28, 12'h180));
      chk("t5_upd_p", {p_hdr_cl_o, p_data_cl_o}, {8'h28, 12'h180});
      send(fc(8'hA0, 8'h05, 12'h005));
      chk("t5_upd_cpl_inf", {cpl_hdr_cl_o, cpl_data_cl_o}, 0);
      send(fc(8'h90, 8'h07, 12'h009));
      chk("t5_upd_np", {np_hdr_cl_o, np_data_cl_o}, {8'h07, 12'h000});
      send(fc(8'h40, 8'h33, 12'h033));
      chk("t5_done_ign_init", {p_hdr_cl_o, p_data_cl_o}, {8'h28, 12'h180});

      // Link down reinitialises everything
      @(negedge clk);
      dl_up_i = 1'b0;
      @(negedge clk);
      chk("dl_down_ackd", ackd_seq_o, 12'hFFF);
      chk("dl_down_fc", {fc_init1_done_o, fc_init_done_o, p_hdr_cl_o, p_data_cl_o, np_inf_o, cpl_inf_o}, 0);
      dl_up_i = 1'b1;
      send(fc(8'h40, 8'h10, 12'h010));
      send(fc(8'hD0, 8'h10, 12'h010));
      send(fc(8'h60, 8'h10, 12'h010));
      chk("t6_init1_again", fc_init1_done_o, 1'b1);

      // 6: back-to-back Acks, then link down
      next_tx_seq_i = 12'h00A;
      @(negedge clk);
      dllp_i = acknak(1'b0, 12'h001); dllp_valid_i = 1'b1;
      @(negedge clk);
      dllp_i = acknak(1'b0, 12'h002);
      @(negedge clk);
      dllp_i = acknak(1'b0, 12'h003);
      chk("t6_ackd1", ackd_seq_o, 12'h001);
      @(negedge clk);
      dllp_valid_i = 1'b0;
      chk("t6_ackd2", {ackd_seq_o, ack_upd_o}, {12'h002, 1'b1});
      @(negedge clk);
      chk("t6_ackd3", {ackd_seq_o, ack_upd_o}, {12'h003, 1'b1});
      dl_up_i = 1'b0;
      @(negedge clk);
      chk("t6_down", {ackd_seq_o, ack_upd_o, fc_init1_done_o}, {12'hFFF, 1'b0, 1'b0});
      dl_up_i = 1'b1;

      // Half-range boundaries and wrap
      next_tx_seq_i = 12'h7FF;
      send(acknak(1'b0, 12'h7FE));
      chk("w_7fe", ackd_seq_o, 12'h7FE);
      next_tx_seq_i = 12'hFFF;
      send(acknak(1'b0, 12'hFFE));
      chk("w_diff800", {ackd_seq_o, ack_upd_o, proto_err_o}, {12'h7FE, 1'b0, 1'b0});
      next_tx_seq_i = 12'hFFE;
      send(acknak(1'b0, 12'hFFD));
      chk("w_ffd", ackd_seq_o, 12'hFFD);
      next_tx_seq_i = 12'hFFF;
      send(acknak(1'b0, 12'hFFE));
      chk("w_ffe", ackd_seq_o, 12'hFFE);
      next_tx_seq_i = 12'h005;
      send(acknak(1'b0, 12'h001));
      chk("w_wrap", {ackd_seq_o, ack_upd_o, proto_err_o}, {12'h001, 1'b1, 1'b0});
      next_tx_seq_i = 12'h00A;
      send(acknak(1'b0, 12'h00A));
      chk("w_win_edge_bad", {ackd_seq_o, proto_err_o}, {12'h001, 1'b1});
      send(acknak(1'b0, 12'h009));
      chk("w_win_edge_ok", {ackd_seq_o, proto_err_o}, {12'h009, 1'b0});

      // Async reset with a DLLP in flight
      next_tx_seq_i = 12'h00F;
      @(negedge clk);
      dllp_i = acknak(1'b0, 12'h00B); dllp_valid_i = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      dllp_valid_i = 1'b0;
      chk("arst_ackd", ackd_seq_o, 12'hFFF);
      rst = 1'b0;
      @(negedge clk);
      chk("arst_lost", {ackd_seq_o, ack_upd_o, proto_err_o}, {12'hFFF, 1'b0, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
